clock_prog_ctrl: RTL and testbench
==================================

CLOCK_PROG_CTRL -- requirements
Module: clock_prog_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the divide and high-phase fields.
REQ-002 SHALL have parameter BURST_W, default 8, width of the burst-length field and period counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_valid, input, 1, configuration request.
REQ-006 SHALL have port cfg_ready, output, 1, configuration accepted when cfg_valid and cfg_ready are both high.
REQ-007 SHALL have port cfg_div, input, CNT_W, programmed period in clk cycles.
REQ-008 SHALL have port cfg_high, input, CNT_W, high-phase length in clk cycles.
REQ-009 SHALL have port cfg_burst, input, BURST_W, number of periods to generate; 0 means continuous.
REQ-010 SHALL have port stop, input, 1, graceful stop request.
REQ-011 SHALL have port clk_en, output, 1, registered programmable clock waveform.
REQ-012 SHALL have port tick, output, 1, one-cycle pulse in every cycle where a period starts.
REQ-013 SHALL have port busy, output, 1, high in RUN and STOPPING.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on return to IDLE.
REQ-015 SHALL have port period_cnt, output, BURST_W, count of completed periods since the last accept; wraps modulo 2^BURST_W.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN and STOPPING.
REQ-017 cfg_ready SHALL be high only in IDLE; a handshake in IDLE latches div, high and burst and enters RUN on the next edge.
REQ-018 Latched div SHALL clamp: values below 2 become 2.
REQ-019 Latched high SHALL clamp: 0 becomes 1, and values of div or more become div-1.
REQ-020 Phase counter SHALL run 0..div-1, cleared to 0 on accept, and wrap from div-1 to 0.
REQ-021 In RUN and STOPPING, clk_en SHALL be 1 when phase < high and 0 otherwise; in IDLE, clk_en SHALL be 0.
REQ-022 clk_en and tick SHALL be valid from the first cycle after the accept cycle (latency 1).
REQ-023 tick SHALL be 1 in every busy cycle with phase == 0.
REQ-024 period_cnt SHALL clear on accept and increment on every phase wrap.
REQ-025 Finite burst: on the wrap that completes period number burst, the FSM SHALL go to IDLE and pulse done.
REQ-026 stop in RUN SHALL move the FSM to STOPPING; the current period completes, then the wrap returns it to IDLE with done.
REQ-027 stop in IDLE or STOPPING SHALL be ignored.
REQ-028 If stop coincides with the final burst wrap, the FSM SHALL go directly to IDLE with exactly one done pulse.
REQ-029 cfg_valid while busy SHALL be ignored with no latch; the FSM SHALL not accept it in the same cycle that done pulses.
REQ-030 Continuous mode (burst = 0) SHALL end only via stop.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, phase 0, clk_en 0, tick 0, busy 0, done 0, period_cnt 0 and cfg_ready 1, including mid-period.
REQ-032 No done pulse SHALL be generated by reset.

Structure
REQ-033 The FSM state enum and the MIN_DIV = 2 constant SHALL live in the shared package clock_prog_pkg.
REQ-034 The phase counter with its wrap detect SHALL be the sub-module clock_prog_phase_cnt; the FSM and clamping SHALL stay in the top level.

Verification
REQ-035 div=4, high=2, burst=3: clk_en SHALL read 1100 1100 1100, ticks at cycles 1, 5 and 9 after accept, done at the third wrap, and period_cnt=3.
REQ-036 div=1, high=0, burst=2: clamped to div 2 and high 1, clk_en SHALL read 10 10, then done.
REQ-037 div=5, high=7, burst=0, stop asserted at phase 2 of period 4: clk_en SHALL read 11110 until the end of period 4, then done, and period_cnt=4.
REQ-038 div=3, burst=2, stop asserted in the final wrap cycle: exactly one done, and IDLE on the next cycle.
REQ-039 reset_n asserted at phase 1 of a div=6 run: all outputs SHALL go to reset values without waiting for clk, no done, and a new config accepted after release.
REQ-040 cfg_valid held high during a run with different values: no effect until after done, then accepted with the new values.

Source files
------------

// File: rtl/clock_prog_pkg.sv
// clock_prog_pkg: shared FSM state type and constants for the programmable clock controller.
package clock_prog_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
    localparam int MIN_DIV = 2;
endpackage

// File: rtl/clock_prog_phase_cnt.sv
// clock_prog_phase_cnt: phase counter running 0..div-1 with wrap detect and look-ahead next value.
module clock_prog_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] phase,
    output logic [CNT_W-1:0] phase_nx,
    output logic             wrap
);
    assign wrap     = en && (phase == div - 1'b1);
    assign phase_nx = clr ? '0 : (en && !wrap) ? phase + 1'b1 : '0;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) phase <= '0;
        else          phase <= phase_nx;
endmodule

// File: rtl/clock_prog_ctrl.sv
// clock_prog_ctrl: programmable clock-enable generator with burst/continuous modes and graceful stop.
module clock_prog_ctrl
    import clock_prog_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               stop,
    output logic               clk_en,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] period_cnt
);
    state_t state, state_nx;
    logic [CNT_W-1:0] div_q, high_q, div_c, high_c, high_nx, phase, phase_nx;
    logic [BURST_W-1:0] burst_q;
    logic accept, wrap, last, busy_nx;

    // Holding ready low during the done pulse keeps back-to-back configs one cycle apart.
    assign cfg_ready = (state == IDLE) && !done;
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = state != IDLE;
    assign busy_nx   = state_nx != IDLE;
    assign div_c     = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;
    assign high_c    = (cfg_high == '0) ? CNT_W'(1) : (cfg_high >= div_c) ? div_c - 1'b1 : cfg_high;
    assign high_nx   = accept ? high_c : high_q;
    assign last      = (burst_q != '0) && (BURST_W'(period_cnt + 1'b1) == burst_q);

    clock_prog_phase_cnt #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (accept),
        .en       (busy),
        .div      (div_q),
        .phase    (phase),
        .phase_nx (phase_nx),
        .wrap     (wrap)
    );

    // A stop arriving on a wrap ends the run there, since that period has just completed.
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = accept ? RUN : IDLE;
        else if (wrap && (state == STOPPING || stop || last))
            state_nx = IDLE;
        else if (state == RUN && stop)
            state_nx = STOPPING;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    // Outputs are registered from look-ahead values so they line up with the phase register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= CNT_W'(MIN_DIV);
            high_q     <= CNT_W'(1);
            burst_q    <= '0;
            period_cnt <= '0;
            clk_en     <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (accept) begin
                div_q   <= div_c;
                high_q  <= high_c;
                burst_q <= cfg_burst;
            end
            period_cnt <= accept ? '0 : wrap ? period_cnt + 1'b1 : period_cnt;
            clk_en     <= busy_nx && (phase_nx < high_nx);
            tick       <= busy_nx && (phase_nx == '0);
            done       <= busy && !busy_nx;
        end
    end
endmodule

// File: tb/tb_clock_prog_ctrl.sv
// tb_clock_prog_ctrl: scoreboard bench; stimulus queues expected busy/done cycles, a monitor checks them.
module tb_clock_prog_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_div = '0;
    logic [7:0] cfg_high = '0;
    logic [7:0] cfg_burst = '0;
    logic       stop = 1'b0;
    logic       clk_en, tick, busy, done;
    logic [7:0] period_cnt;

    typedef struct packed {
        logic       ce;
        logic       tk;
        logic       dn;
        logic       rdy;
        logic [7:0] pc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;
    int last_len = 0;

    clock_prog_ctrl #(.CNT_W(8), .BURST_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .cfg_burst  (cfg_burst),
        .stop       (stop),
        .clk_en     (clk_en),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour: one record per busy cycle after accept, then one done record.
    task automatic push_run(input int d, input int h, input int b, input int stop_at);
        int dc;
        int hc;
        int k;
        bit fin;
        dc = (d < 2) ? 2 : d;
        hc = (h == 0) ? 1 : (h >= dc) ? dc - 1 : h;
        k = 0;
        fin = 0;
        while (!fin) begin
            int ph;
            k++;
            ph = (k - 1) % dc;
            q.push_back('{ce: ph < hc, tk: ph == 0, dn: 1'b0, rdy: 1'b0, pc: 8'((k - 1) / dc)});
            if (ph == dc - 1 && ((b != 0 && k / dc == b) || (stop_at != 0 && stop_at <= k))) fin = 1;
        end
        q.push_back('{ce: 1'b0, tk: 1'b0, dn: 1'b1, rdy: 1'b0, pc: 8'(k / dc)});
        last_len = k;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !cfg_ready; i++) begin
            @(posedge clk);
            #1;
        end
        if (!cfg_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic run(input int d, input int h, input int b, input int stop_at, input int pc_exp);
        push_run(d, h, b, stop_at);
        wait_ready();
        cfg_valid = 1'b1;
        cfg_div = 8'(d);
        cfg_high = 8'(h);
        cfg_burst = 8'(b);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        for (int k = 1; k <= last_len; k++) begin
            stop = (k == stop_at);
            @(posedge clk);
            #1;
        end
        stop = 1'b0;
        @(posedge clk);
        #1;
        chk("period_cnt_final", period_cnt, pc_exp);
        chk("busy_after_run", busy, 0);
        chk("queue_drained", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && (busy || done)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("clk_en", clk_en, e.ce);
                chk("tick", tick, e.tk);
                chk("done", done, e.dn);
                chk("cfg_ready", cfg_ready, e.rdy);
                chk("period_cnt", period_cnt, e.pc);
            end
        end
    end

    initial begin
        int l1;
        int l2;
        #12;
        chk("rst_clk_en", clk_en, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_period_cnt", period_cnt, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run(4, 2, 3, 0, 3);
        run(1, 0, 2, 0, 2);
        run(5, 7, 0, 18, 4);
        run(3, 1, 2, 6, 2);

        // stop while idle must not start or disturb anything
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("idle_stop_busy", busy, 0);
        chk("idle_stop_done", done, 0);

        // reset in the middle of a period
        q.push_back('{ce: 1'b1, tk: 1'b1, dn: 1'b0, rdy: 1'b0, pc: 8'd0});
        wait_ready();
        cfg_valid = 1'b1;
        cfg_div = 8'd6;
        cfg_high = 8'd3;
        cfg_burst = 8'd0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_clk_en", clk_en, 0);
        chk("arst_tick", tick, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_period_cnt", period_cnt, 0);
        chk("arst_cfg_ready", cfg_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_no_done", done, 0);
        chk("arst_queue", q.size(), 0);
        run(2, 1, 1, 0, 1);

        // cfg_valid held through a run with new values
        push_run(4, 1, 2, 0);
        l1 = last_len;
        push_run(3, 2, 1, 0);
        l2 = last_len;
        wait_ready();
        cfg_valid = 1'b1;
        cfg_div = 8'd4;
        cfg_high = 8'd1;
        cfg_burst = 8'd2;
        @(posedge clk);
        #1;
        cfg_div = 8'd3;
        cfg_high = 8'd2;
        cfg_burst = 8'd1;
        repeat (l1) begin
            @(posedge clk);
            #1;
        end
        chk("hold_done_cycle", done, 1);
        chk("hold_ready_at_done", cfg_ready, 0);
        @(posedge clk);
        #1;
        chk("hold_ready_after_done", cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        chk("hold_second_busy", busy, 1);
        repeat (l2) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("hold_period_cnt", period_cnt, 1);
        chk("hold_queue", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
